fifo_byte_serializer: RTL and testbench

- Downstream consumer of the Fifo block: pops SIZE-bit words through the Fifo's valid/ready pop handshake and emits them as OUT_W-bit beats on a valid/ready stream.
- Counts words into fixed bursts and marks the final beat of each burst with last_o, so the downstream link sees framed packets.
- Sustains one beat per cycle across word boundaries when neither side stalls.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/fifo_byte_serializer_if.sv | 24 ++
 rtl/fifo_byte_serializer.sv | 133 +++++++++++++
 tb/tb_fifo_byte_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Types and defaults shared by the Fifo and its byte serializer consumer.
// Keep SIZE/OUT_W defaults here so both blocks agree on word geometry.
package fifo_pkg;

    localparam int FIFO_SIZE  = 32;
    localparam int FIFO_OUT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CSUM
    } state_t;

    function automatic int beats_f(input int size, input int out_w);
        return size / out_w;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_if.sv
// Upstream word pop handshake plus downstream beat stream of the serializer.
// slave is the serializer side, master is the side that drives its inputs.
interface fifo_byte_serializer_if #(
    parameter int SIZE  = fifo_pkg::FIFO_SIZE,
    parameter int OUT_W = fifo_pkg::FIFO_OUT_W
);
    logic             valid_i;
    logic [SIZE-1:0]  data_i;
    logic             ready_o;
    logic             valid_o;
    logic [OUT_W-1:0] data_o;
    logic             last_o;
    logic             ready_i;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, last_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, last_o
    );
endinterface

// File: rtl/fifo_byte_serializer.sv
// Pops SIZE-bit words and emits OUT_W-bit framed beats; 1-cycle accept-to-beat latency, zero-bubble
// across words; downstream stall freezes beat, last and counters. FIFO_BYTE_SERIALIZER_CHECKSUM_EN appends an XOR beat per burst.
module fifo_byte_serializer
    import fifo_pkg::*;
#(
    parameter int SIZE        = FIFO_SIZE,
    parameter int OUT_W       = FIFO_OUT_W,
    parameter int BURST_WORDS = 4,
    parameter bit MSB_FIRST   = 1'b1
) (
    input logic                    clk_i,
    input logic                    rst_i,
    fifo_byte_serializer_if.slave  bus
);

    localparam int BEATS = beats_f(SIZE, OUT_W);
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW   = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BEATS - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(BURST_WORDS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [BCW-1:0]   beat_cnt;
    logic [WCW-1:0]   word_cnt;
    logic [SIZE-1:0]  shreg;
    logic [OUT_W-1:0] cur_beat;
    logic             last_beat;
    logic             last_word;
    logic             accept;
    logic             beat_hs;
    logic             csum_pend;

    assign cur_beat  = MSB_FIRST ? shreg[SIZE-1 -: OUT_W] : shreg[OUT_W-1:0];
    assign last_beat = (beat_cnt == BEAT_LAST);
    assign last_word = (word_cnt == WORD_LAST);
    assign accept    = bus.valid_i && bus.ready_o;
    assign beat_hs   = (state == SHIFT) && bus.valid_o && bus.ready_i;

`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    logic [OUT_W-1:0] csum;
    // The final word of a burst hands over to the checksum beat, not a new word.
    assign csum_pend = last_word;
`else
    assign csum_pend = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.ready_o = 1'b0;
        bus.valid_o = 1'b0;
        bus.data_o  = '0;
        bus.last_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    bus.ready_o = 1'b1;
                    if (bus.valid_i) state_nxt = SHIFT;
                end
                SHIFT: begin
                    bus.valid_o = 1'b1;
                    bus.data_o  = cur_beat;
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
                    bus.last_o  = 1'b0;
`else
                    bus.last_o  = last_beat && last_word;
`endif
                    // Combinational from ready_i so the next word lands on the same edge.
                    bus.ready_o = last_beat && bus.ready_i && !csum_pend;
                    if (bus.ready_i && last_beat) begin
                        if (csum_pend)        state_nxt = CSUM;
                        else if (bus.valid_i) state_nxt = SHIFT;
                        else                  state_nxt = IDLE;
                    end
                end
                CSUM: begin
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
                    bus.valid_o = 1'b1;
                    bus.data_o  = csum;
                    bus.last_o  = 1'b1;
                    if (bus.ready_i) state_nxt = IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt <= '0;
            word_cnt <= '0;
            shreg    <= '0;
        end else begin
            if (beat_hs) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    word_cnt <= last_word ? '0 : word_cnt + 1'b1;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    shreg    <= MSB_FIRST ? (shreg << OUT_W) : (shreg >> OUT_W);
                end
            end
            if (accept) begin
                shreg    <= bus.data_i;
                beat_cnt <= '0;
            end
        end
    end

`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            csum <= '0;
        end else if (beat_hs) begin
            csum <= csum ^ cur_beat;
        end else if ((state == CSUM) && bus.ready_i) begin
            csum <= '0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Scoreboarded bench: accepted words are expanded into expected beats by a word-level model,
// and an independent monitor pops and compares every beat the serializer hands off.
module tb_fifo_byte_serializer;

    localparam int SIZE        = 32;
    localparam int OUT_W       = 8;
    localparam int BURST_WORDS = 4;
    localparam bit MSB_FIRST   = 1'b1;
    localparam int BEATS       = SIZE / OUT_W;
`ifdef FIFO_BYTE_SERIALIZER_CHECKSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    typedef struct packed {
        logic [OUT_W-1:0] d;
        logic             l;
    } exp_t;

    typedef struct packed {
        logic [SIZE-1:0] w;
        int unsigned     gap;
    } tx_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_byte_serializer_if #(.SIZE(SIZE), .OUT_W(OUT_W)) bus ();

    fifo_byte_serializer #(
        .SIZE(SIZE), .OUT_W(OUT_W), .BURST_WORDS(BURST_WORDS), .MSB_FIRST(MSB_FIRST)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    exp_t exp_q[$];
    tx_t  tx_q[$];
    int   hs_cyc[$];
    int   m_idx = 0;
    logic [OUT_W-1:0] m_csum = '0;
    bit   drv_busy = 1'b0;
    int   last_acc_cyc = 0;
    bit   rnd_rdy = 1'b0;
    bit   rdy_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Word-level reference: split into beats, frame every BURST_WORDS words.
    task automatic model_push(input logic [SIZE-1:0] w);
        exp_t e;
        logic [OUT_W-1:0] b;
        for (int i = 0; i < BEATS; i++) begin
            if (MSB_FIRST) b = OUT_W'(w >> (SIZE - OUT_W * (i + 1)));
            else           b = OUT_W'(w >> (OUT_W * i));
            e.d = b;
            e.l = !CSUM_ON && (m_idx == BURST_WORDS - 1) && (i == BEATS - 1);
            exp_q.push_back(e);
            m_csum = m_csum ^ b;
        end
        if (CSUM_ON && (m_idx == BURST_WORDS - 1)) begin
            e.d = m_csum;
            e.l = 1'b1;
            exp_q.push_back(e);
            m_csum = '0;
        end
        m_idx = (m_idx + 1) % BURST_WORDS;
    endtask

    // Upstream driver: presents queued words and waits for the pop handshake.
    initial begin
        tx_t it;
        bit  acc;
        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        @(posedge clk); #1;
        forever begin
            if (tx_q.size() == 0) begin
                bus.valid_i = 1'b0;
                drv_busy    = 1'b0;
                @(posedge clk); #1;
            end else begin
                it       = tx_q.pop_front();
                drv_busy = 1'b1;
                if (it.gap > 0) begin
                    bus.valid_i = 1'b0;
                    repeat (it.gap) begin @(posedge clk); #1; end
                end
                bus.valid_i = 1'b1;
                bus.data_i  = it.w;
                acc = 1'b0;
                for (int t = 0; t < 500 && !acc; t++) begin
                    @(negedge clk);
                    if (!rst && bus.ready_o) begin
                        acc = 1'b1;
                        last_acc_cyc = cyc;
                    end
                    @(posedge clk); #1;
                end
                if (acc) model_push(it.w);
                else check("accept_timeout", 32'(acc), 32'd1);
            end
        end
    end

    // Downstream ready driver.
    initial begin
        bus.ready_i = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.ready_i = rnd_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;
        end
    end

    // Monitor: compare every handshaken beat, and hold-stability under stall.
    initial begin
        bit               prev_stall = 1'b0;
        logic [OUT_W-1:0] prev_d = '0;
        logic             prev_l = 1'b0;
        exp_t             e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 32'(bus.valid_o), 32'd1);
                    check("hold_data", 32'(bus.data_o), 32'(prev_d));
                    check("hold_last", 32'(bus.last_o), 32'(prev_l));
                end
                if (bus.valid_o) begin
                    check("ready_o_needs_ready_i", 32'(bus.ready_o && !bus.ready_i), 32'd0);
                    if (bus.ready_i) begin
                        hs_cyc.push_back(cyc);
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got data %0h last %0b, expected no beat (cycle %0d)",
                                     bus.data_o, bus.last_o, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            check("beat_data", 32'(bus.data_o), 32'(e.d));
                            check("beat_last", 32'(bus.last_o), 32'(e.l));
                        end
                    end
                    prev_stall = !bus.ready_i;
                    prev_d     = bus.data_o;
                    prev_l     = bus.last_o;
                end else begin
                    prev_stall = 1'b0;
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        m_idx  = 0;
        m_csum = '0;
        repeat (n) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((tx_q.size() != 0 || drv_busy || exp_q.size() != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain_in_time", 32'(t < 3000), 32'd1);
        @(negedge clk);
    endtask

    task automatic send(input logic [SIZE-1:0] w, input int unsigned gap);
        tx_t it;
        it.w   = w;
        it.gap = gap;
        tx_q.push_back(it);
    endtask

    task automatic check_contiguous(input string nm, input int n);
        check({nm, "_count"}, 32'(hs_cyc.size()), 32'(n));
        if (hs_cyc.size() > 0)
            check({nm, "_span"}, 32'(hs_cyc[hs_cyc.size()-1] - hs_cyc[0]), 32'(n - 1));
    endtask

    initial begin
        int t;
        // Reset state, with outputs gated during reset.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_o", 32'(bus.valid_o), 32'd0);
        check("rst_ready_o", 32'(bus.ready_o), 32'd0);
        check("rst_data_o", 32'(bus.data_o), 32'd0);
        check("rst_last_o", 32'(bus.last_o), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready_o", 32'(bus.ready_o), 32'd1);

        // Single word: 1-cycle latency, four contiguous beats.
        hs_cyc.delete();
        send(32'habcdefaa, 0);
        drain();
        check_contiguous("single_word", BEATS);
        if (hs_cyc.size() > 0) check("first_beat_latency", 32'(hs_cyc[0] - last_acc_cyc), 32'd1);

        // Full burst back-to-back from word 0.
        do_reset(2);
        hs_cyc.delete();
        send(32'habcdefaa, 0);
        send(32'hdeaddead, 0);
        send(32'haaaaaaaa, 0);
        send(32'hdddddddd, 0);
        drain();
        check_contiguous("burst", BURST_WORDS * BEATS + (CSUM_ON ? 1 : 0));

        // Backpressure on the second beat of deaddead.
        do_reset(2);
        send(32'habcdefaa, 0);
        send(32'hdeaddead, 0);
        send(32'haaaaaaaa, 0);
        send(32'hdddddddd, 0);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(bus.valid_o && bus.data_o == 8'hde) && t < 200);
        check("saw_deaddead", 32'(t < 200), 32'd1);
        rdy_force = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_valid_o", 32'(bus.valid_o), 32'd1);
            check("bp_data_o", 32'(bus.data_o), 32'h0000_00ad);
            check("bp_ready_o", 32'(bus.ready_o), 32'd0);
        end
        rdy_force = 1'b1;
        drain();

        // Upstream underflow mid-burst keeps the word count.
        do_reset(2);
        send(32'h01020304, 0);
        send(32'h05060708, 0);
        drain();
        repeat (10) @(negedge clk);
        check("underflow_valid_o", 32'(bus.valid_o), 32'd0);
        check("underflow_ready_o", 32'(bus.ready_o), 32'd1);
        send(32'h090a0b0c, 0);
        send(32'h0d0e0f10, 0);
        drain();

        // Reset while beat 1 is on the output.
        hs_cyc.delete();
        send(32'h11223344, 0);
        t = 0;
        while (hs_cyc.size() < 1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("saw_beat0", 32'(hs_cyc.size() >= 1), 32'd1);
        @(posedge clk); #2;
        rst = 1'b1;
        exp_q.delete();
        m_idx  = 0;
        m_csum = '0;
        @(negedge clk);
        check("midrst_valid_o", 32'(bus.valid_o), 32'd0);
        check("midrst_ready_o", 32'(bus.ready_o), 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        for (int i = 0; i < BURST_WORDS; i++) send($urandom, 0);
        drain();

        // Randomized traffic with random stalls on both sides.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 48; i++)
            send($urandom, ($urandom_range(0, 5) == 0) ? $urandom_range(1, 6) : 0);
        drain();
        rnd_rdy = 1'b0;

        repeat (4) @(negedge clk);
        check("no_leftover_beats", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
